// File: rtl/obj_drop_sched.sv
// obj_drop_sched: per-frame scheduler that spawns, drops and retires objects across NSLOT slots
// ports: clk, rst (sync, active-high), frame_tick, start, pause, rd_idx -> rd_x/rd_y/rd_active,
//        active_mask, spawned_cnt, retired_cnt, retire_pulse, state, end_show
// OBJ_DROP_LFSR_EN: defined -> spawn x from a 16-bit LFSR, undefined -> fixed 5-column x sequence
module obj_drop_sched #(
  parameter int          NSLOT     = 4,
  parameter logic [11:0] Y_MAX     = 12'd440,
  parameter logic [11:0] STEP      = 12'd2,
  parameter int          SPAWN_GAP = 30,
  parameter logic [7:0]  TOTAL     = 8'd5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             start,
  input  logic             pause,
  input  logic [2:0]       rd_idx,
  output logic [11:0]      rd_x,
  output logic [11:0]      rd_y,
  output logic             rd_active,
  output logic [NSLOT-1:0] active_mask,
  output logic [7:0]       spawned_cnt,
  output logic [7:0]       retired_cnt,
  output logic             retire_pulse,
  output logic [1:0]       state,
  output logic             end_show
);
  localparam int GW = $clog2(SPAWN_GAP) + 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(SPAWN_GAP - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t st, st_nx;
  logic [GW-1:0] gap_cnt;
  logic [11:0] x_q [NSLOT];
  logic [11:0] y_q [NSLOT];
  logic [11:0] x_d [NSLOT];
  logic [11:0] y_d [NSLOT];
  logic [NSLOT-1:0] act_d, spawn_oh;
  logic [7:0] ret_n;
  logic [11:0] new_x;
  logic enter, tick, spawn;
  assign state = st;
  assign end_show = st == DONE;
  assign enter = (st == IDLE || st == DONE) && start;
  assign tick = frame_tick && st == RUN && !pause;
  // lowest clear bit of the pre-tick mask: slots retiring this tick are not candidates
  assign spawn_oh = ~active_mask & (active_mask + NSLOT'(1));
  assign spawn = gap_cnt == GAP_LAST && spawned_cnt < TOTAL && !(&active_mask);
`ifdef OBJ_DROP_LFSR_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk)
    lfsr <= rst ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign new_x = (lfsr[9:0] < 10'd600) ? {2'b00, lfsr[9:0]} : {2'b00, lfsr[9:0] - 10'd600};
`else
  assign new_x = 12'd60 + 12'd120 * 12'(spawned_cnt % 8'd5);
`endif
  always_comb begin
    st_nx = (st == IDLE || st == DONE) ? (start ? RUN : st)
          : (st == RUN) ? (pause ? PAUSE : (spawned_cnt == TOTAL && active_mask == '0) ? DONE : RUN)
          : (pause ? PAUSE : RUN);
  end
  always_comb begin
    act_d = active_mask;
    x_d = x_q;
    y_d = y_q;
    ret_n = '0;
    for (int i = 0; i < NSLOT; i++)
      if (spawn && spawn_oh[i]) begin
        act_d[i] = 1'b1;
        x_d[i] = new_x;
        y_d[i] = '0;
      end else if (active_mask[i] && y_q[i] == Y_MAX) begin
        act_d[i] = 1'b0;
        y_d[i] = '0;
        ret_n = ret_n + 8'd1;
      end else if (active_mask[i])
        y_d[i] = (13'(y_q[i]) + 13'(STEP) >= 13'(Y_MAX)) ? Y_MAX : y_q[i] + STEP;
  end
  always_comb begin
    rd_x = x_q[0];
    rd_y = y_q[0];
    rd_active = active_mask[0];
    for (int i = 1; i < NSLOT; i++)
      if (rd_idx == 3'(i)) begin
        rd_x = x_q[i];
        rd_y = y_q[i];
        rd_active = active_mask[i];
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      st <= IDLE;
      active_mask <= '0;
      spawned_cnt <= '0;
      retired_cnt <= '0;
      gap_cnt <= '0;
      retire_pulse <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        x_q[i] <= 12'd300;
        y_q[i] <= '0;
      end
    end else begin
      st <= st_nx;
      retire_pulse <= tick && ret_n != '0;
      if (enter) begin
        active_mask <= '0;
        spawned_cnt <= '0;
        retired_cnt <= '0;
        gap_cnt <= GAP_LAST;
        for (int i = 0; i < NSLOT; i++) y_q[i] <= '0;
      end else if (tick) begin
        active_mask <= act_d;
        x_q <= x_d;
        y_q <= y_d;
        spawned_cnt <= spawned_cnt + 8'(spawn);
        retired_cnt <= retired_cnt + ret_n;
        gap_cnt <= spawn ? '0 : (gap_cnt == GAP_LAST) ? gap_cnt : gap_cnt + GW'(1);
      end
    end
endmodule

// File: tb/tb_obj_drop_sched.sv
// tb_obj_drop_sched: checks a default and a small obj_drop_sched against a behavioural model plus literals
module tb_obj_drop_sched;
  logic clk = 0, rst, frame_tick, start, pause;
  logic [2:0] rd_idx;
  logic [11:0] d0_rx, d0_ry, d1_rx, d1_ry;
  logic d0_ra, d1_ra, d0_pulse, d1_pulse, d0_end, d1_end;
  logic [3:0] d0_mask;
  logic [1:0] d1_mask, d0_state, d1_state;
  logic [7:0] d0_sp, d0_rt, d1_sp, d1_rt;
  int n_cmp = 0, n_bad = 0;
  bit chk = 0;
  always #5 clk = ~clk;

  obj_drop_sched u0 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause), .rd_idx(rd_idx),
    .rd_x(d0_rx), .rd_y(d0_ry), .rd_active(d0_ra), .active_mask(d0_mask),
    .spawned_cnt(d0_sp), .retired_cnt(d0_rt), .retire_pulse(d0_pulse), .state(d0_state), .end_show(d0_end));

  obj_drop_sched #(.NSLOT(2), .Y_MAX(12'd4), .STEP(12'd2), .SPAWN_GAP(1), .TOTAL(8'd5)) u1 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause), .rd_idx(rd_idx),
    .rd_x(d1_rx), .rd_y(d1_ry), .rd_active(d1_ra), .active_mask(d1_mask),
    .spawned_cnt(d1_sp), .retired_cnt(d1_rt), .retire_pulse(d1_pulse), .state(d1_state), .end_show(d1_end));

  function automatic int p_n(input int k); return k == 0 ? 4 : 2; endfunction
  function automatic int p_ymax(input int k); return k == 0 ? 440 : 4; endfunction
  function automatic int p_gap(input int k); return k == 0 ? 30 : 1; endfunction
  localparam int STEP_V = 2, TOTAL_V = 5;

  int m_st[2], m_sp[2], m_rt[2], m_gap[2], m_pulse[2];
  bit m_act[2][8];
  int m_x[2][8], m_y[2][8];
  logic [15:0] m_lfsr[2];

  task automatic cmp(input string nm, input int a, input int e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic chk_x(input string nm, input int a, input int e);
`ifdef OBJ_DROP_LFSR_EN
    cmp(nm, int'(a < 600), 1);
`else
    cmp(nm, a, e);
`endif
  endtask

  task automatic model_step(input int k);
    int f, nx, nret, nst;
    bit any;
    if (rst) begin
      m_st[k] = 0; m_sp[k] = 0; m_rt[k] = 0; m_gap[k] = 0; m_pulse[k] = 0;
      m_lfsr[k] = 16'hACE1;
      for (int i = 0; i < 8; i++) begin m_act[k][i] = 0; m_x[k][i] = 300; m_y[k][i] = 0; end
      return;
    end
    any = 0;
    for (int i = 0; i < p_n(k); i++) any |= m_act[k][i];
    case (m_st[k])
      0, 3: nst = start ? 1 : m_st[k];
      1: nst = pause ? 2 : (m_sp[k] == TOTAL_V && !any) ? 3 : 1;
      default: nst = pause ? 2 : 1;
    endcase
    m_pulse[k] = 0;
    if ((m_st[k] == 0 || m_st[k] == 3) && start) begin
      for (int i = 0; i < 8; i++) begin m_act[k][i] = 0; m_y[k][i] = 0; end
      m_sp[k] = 0; m_rt[k] = 0; m_gap[k] = p_gap(k) - 1;
    end else if (m_st[k] == 1 && !pause && frame_tick) begin
      f = -1;
      for (int i = 0; i < p_n(k); i++) if (!m_act[k][i] && f < 0) f = i;
`ifdef OBJ_DROP_LFSR_EN
      nx = int'(m_lfsr[k][9:0]);
      if (nx >= 600) nx -= 600;
`else
      nx = 60 + 120 * (m_sp[k] % 5);
`endif
      nret = 0;
      for (int i = 0; i < p_n(k); i++)
        if (m_act[k][i]) begin
          if (m_y[k][i] == p_ymax(k)) begin m_act[k][i] = 0; m_y[k][i] = 0; nret++; end
          else m_y[k][i] = (m_y[k][i] + STEP_V > p_ymax(k)) ? p_ymax(k) : m_y[k][i] + STEP_V;
        end
      if (m_gap[k] == p_gap(k) - 1) begin
        if (m_sp[k] < TOTAL_V && f >= 0) begin
          m_act[k][f] = 1; m_y[k][f] = 0; m_x[k][f] = nx; m_sp[k]++; m_gap[k] = 0;
        end
      end else m_gap[k]++;
      m_rt[k] += nret;
      m_pulse[k] = int'(nret > 0);
    end
    m_lfsr[k] = {m_lfsr[k][14:0], m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10]};
    m_st[k] = nst;
  endtask

  task automatic check_dut(input int k, input int st, input int en, input int mask, input int sp,
                           input int rt, input int pu, input int rx, input int ry, input int ra);
    int m = 0, ri;
    for (int i = 0; i < p_n(k); i++) if (m_act[k][i]) m |= 1 << i;
    ri = (int'(rd_idx) < p_n(k)) ? int'(rd_idx) : 0;
    cmp($sformatf("u%0d_state", k), st, m_st[k]);
    cmp($sformatf("u%0d_end_show", k), en, int'(m_st[k] == 3));
    cmp($sformatf("u%0d_active_mask", k), mask, m);
    cmp($sformatf("u%0d_spawned", k), sp, m_sp[k]);
    cmp($sformatf("u%0d_retired", k), rt, m_rt[k]);
    cmp($sformatf("u%0d_retire_pulse", k), pu, m_pulse[k]);
    cmp($sformatf("u%0d_rd_x", k), rx, m_x[k][ri]);
    cmp($sformatf("u%0d_rd_y", k), ry, m_y[k][ri]);
    cmp($sformatf("u%0d_rd_active", k), ra, int'(m_act[k][ri]));
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(posedge clk) begin
    #1;
    if (chk) begin
      check_dut(0, d0_state, d0_end, d0_mask, d0_sp, d0_rt, d0_pulse, d0_rx, d0_ry, d0_ra);
      check_dut(1, d1_state, d1_end, d1_mask, d1_sp, d1_rt, d1_pulse, d1_rx, d1_ry, d1_ra);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk) frame_tick = 1;
      @(negedge clk) frame_tick = 0;
    end
  endtask

  initial begin
    rst = 1; start = 0; pause = 0; frame_tick = 0; rd_idx = 0;
    repeat (3) @(negedge clk);
    rst = 0; chk = 1;
    cmp("rst_state", d0_state, 0);
    cmp("rst_mask", d0_mask, 0);
    cmp("rst_x", d0_rx, 300);
    cmp("rst_end_show", d0_end, 0);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    cmp("start_state", d0_state, 1);
    tick(1);
    cmp("t1_mask", d0_mask, 1);
    cmp("t1_y", d0_ry, 0);
    cmp("t1_spawned", d0_sp, 1);
    chk_x("t1_x", d0_rx, 60);
    cmp("t1_small_spawned", d1_sp, 1);
    tick(3);
    cmp("t4_small_deferred", d1_sp, 2);
    cmp("t4_small_mask", d1_mask, 2);
    cmp("t4_small_pulse", d1_pulse, 1);
    tick(1);
    cmp("t5_small_spawned", d1_sp, 3);
    cmp("t5_small_mask", d1_mask, 1);
    cmp("t5_small_retired", d1_rt, 2);
    chk_x("t5_small_x", d1_rx, 300);
    cmp("t5_y", d0_ry, 8);
    tick(5);
    cmp("t10_y", d0_ry, 18);
    @(negedge clk) pause = 1;
    tick(50);
    cmp("pause_y", d0_ry, 18);
    cmp("pause_state", d0_state, 2);
    cmp("pause_spawned", d0_sp, 1);
    @(negedge clk) pause = 0;
    @(negedge clk);
    cmp("resume_state", d0_state, 1);
    tick(20);
    cmp("t30_spawned", d0_sp, 1);
    tick(1);
    cmp("t31_spawned", d0_sp, 2);
    tick(190);
    cmp("t221_y", d0_ry, 440);
    cmp("t221_active", d0_ra, 1);
    cmp("t221_retired", d0_rt, 0);
    cmp("t221_spawned_deferred", d0_sp, 4);
    tick(1);
    cmp("t222_pulse", d0_pulse, 1);
    cmp("t222_y", d0_ry, 0);
    cmp("t222_active", d0_ra, 0);
    cmp("t222_retired", d0_rt, 1);
    cmp("t222_spawned", d0_sp, 4);
    tick(1);
    cmp("t223_spawned", d0_sp, 5);
    cmp("t223_active", d0_ra, 1);
    chk_x("t223_x", d0_rx, 540);
    tick(221);
    cmp("t444_retired", d0_rt, 5);
    cmp("t444_mask", d0_mask, 0);
    cmp("t444_state", d0_state, 1);
    @(negedge clk);
    cmp("done_state", d0_state, 3);
    cmp("done_end_show", d0_end, 1);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    cmp("r2_state", d0_state, 1);
    cmp("r2_spawned", d0_sp, 0);
    cmp("r2_retired", d0_rt, 0);
    cmp("r2_end_show", d0_end, 0);
    cmp("r2_small_state", d1_state, 1);
    tick(1);
    cmp("r2_spawned1", d0_sp, 1);
    chk_x("r2_x", d0_rx, 60);
    rd_idx = 7;
    #1;
    cmp("rd7_active", d0_ra, 1);
    chk_x("rd7_x", d0_rx, 60);
    cmp("rd7_small_active", d1_ra, 1);
    rd_idx = 1;
    #1;
    cmp("rd1_active", d0_ra, 0);
    tick(2);
    cmp("r2_small_mask", d1_mask, 3);
    @(negedge clk) begin rst = 1; frame_tick = 1; end
    @(negedge clk) frame_tick = 0;
    cmp("rst_mid_pulse", d1_pulse, 0);
    cmp("rst_mid_state", d1_state, 0);
    cmp("rst_mid_mask", d1_mask, 0);
    cmp("rst_mid_x", d0_rx, 300);
    @(negedge clk) rst = 0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
